// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller and the datapath/caches.
// The master side is the controller: it consumes hazard and cache status
// and drives the latch enables/flushes, the PC enable and the cache requests.
interface pipeline_ctrl_if;
  // Status from datapath and caches
  logic       ihit;
  logic       dhit;
  logic       exmem_DRen;
  logic       exmem_DWen;
  logic       exmem_redirect;
  logic       memwb_halt;
  logic       idex_DRen;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;

  // Control back to datapath and caches
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;
  logic       iREN;
  logic       dREN;
  logic       dWEN;
  logic       halt;

  modport master (
    input  ihit, dhit, exmem_DRen, exmem_DWen, exmem_redirect, memwb_halt,
           idex_DRen, idex_rt, ifid_rs, ifid_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           iREN, dREN, dWEN, halt
  );

  modport slave (
    output ihit, dhit, exmem_DRen, exmem_DWen, exmem_redirect, memwb_halt,
           idex_DRen, idex_rt, ifid_rs, ifid_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           iREN, dREN, dWEN, halt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Waits for both the fetch
// and any MEM-stage data access to complete before advancing every latch,
// remembering which half already finished so it is never reissued. Inserts
// the load-use bubble, squashes on MEM-stage redirects, latches halt and
// counts stall cycles (saturating).
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  pipeline_ctrl_if.master  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,  // both fetch and data (if any) outstanding
    WAIT_D = 2'd1,  // fetch done, data access pending
    WAIT_I = 2'd2,  // data access done, fetch pending
    HALT   = 2'd3   // stopped until reset
  } state_t;

  state_t state, state_next;

  logic mreq;
  logic luh;
  logic adv;
  logic bubble;
  logic halt_entry;
  logic stall_inc;

  assign mreq = bus.exmem_DRen | bus.exmem_DWen;

  // A load in EX whose destination feeds the instruction in ID; $zero never hazards.
  assign luh = bus.idex_DRen && (bus.idex_rt != 5'd0) &&
               ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));

  // A redirect squashes the dependent instruction anyway, so it wins over the bubble.
  assign bubble     = luh & ~bus.exmem_redirect;
  assign halt_entry = bus.memwb_halt & (state != HALT);

  // Bubble cycles are lost issue slots, so they are counted like real stalls.
  assign stall_inc  = (state != HALT) & (~adv | bubble);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  // Next state, advance decision and gated cache requests.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned, which would infer a latch.
    state_next = state;
    adv        = 1'b0;
    bus.iREN   = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    case (state)
      RUN: begin
        bus.iREN = 1'b1;
        bus.dREN = bus.exmem_DRen;
        bus.dWEN = bus.exmem_DWen;
        adv      = bus.ihit & (~mreq | bus.dhit);
        if (bus.ihit & mreq & ~bus.dhit)      state_next = WAIT_D;
        else if (~bus.ihit & mreq & bus.dhit) state_next = WAIT_I;
      end
      WAIT_D: begin
        // Fetched instruction is held; do not refetch.
        bus.dREN = bus.exmem_DRen;
        bus.dWEN = bus.exmem_DWen;
        adv      = bus.dhit;
        if (bus.dhit) state_next = RUN;
      end
      WAIT_I: begin
        // Data access already completed; reissuing a store would double-write.
        bus.iREN = 1'b1;
        adv      = bus.ihit;
        if (bus.ihit) state_next = RUN;
      end
      default: ;  // HALT: everything idle
    endcase
    if (bus.memwb_halt) state_next = HALT;
    if (!nRST) begin
      bus.iREN = 1'b0;
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end
  end

  // Latch enables/flushes and PC enable for the current cycle.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.idex_en     = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.memwb_en    = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.memwb_flush = 1'b0;
    if (adv) begin
      bus.pc_en    = 1'b1;
      bus.ifid_en  = 1'b1;
      bus.idex_en  = 1'b1;
      bus.exmem_en = 1'b1;
      bus.memwb_en = 1'b1;
      if (bubble) begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
      end
      if (bus.exmem_redirect) begin
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_flush = 1'b1;
      end
    end
    // The halting instruction must not retire twice, nor fetch continue.
    if (halt_entry) begin
      bus.pc_en    = 1'b0;
      bus.memwb_en = 1'b0;
    end
    if (!nRST) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.idex_en     = 1'b0;
      bus.exmem_en    = 1'b0;
      bus.memwb_en    = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.idex_flush  = 1'b0;
      bus.exmem_flush = 1'b0;
      bus.memwb_flush = 1'b0;
    end
  end

  assign bus.halt = (state == HALT);

  // Saturating stall-cycle counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                             stall_cnt <= '0;
    else if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches).
- Collects cache handshakes (ihit, dhit), the load-use hazard and the MEM-stage branch/jump redirect.
- Drives the enable/flush pair of every pipeline latch, plus the PC enable and the gated cache requests.
- Latches halt and keeps a saturating stall-cycle counter for per-core performance reporting.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  icache fetch complete this cycle
- dhit  in  1  dcache access complete this cycle
- exmem_DRen  in  1  MEM-stage load
- exmem_DWen  in  1  MEM-stage store
- exmem_redirect  in  1  MEM-stage taken branch/jump/jr
- memwb_halt  in  1  halt instruction in WB
- idex_DRen  in  1  EX-stage instruction is a load
- idex_rt  in  5  EX-stage load destination
- ifid_rs  in  5  ID-stage source register rs
- ifid_rt  in  5  ID-stage source register rt
- pc_en  out  1  PC update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes (bubble insert)
- iREN  out  1  icache read request
- dREN  out  1  gated dcache read request
- dWEN  out  1  gated dcache write request
- halt  out  1  sticky halt to the system
- stall_cnt  out  CNT_W  stall cycles since reset

Behaviour:
- Reset (nRST low, asynchronous):
  - state=RUN, stall_cnt=0, halt=0.
  - All enables, flushes, dREN and dWEN are 0 while nRST is low. iREN=1 once reset is released.
- Derived signals:
  - mreq = exmem_DRen|exmem_DWen
  - luh = idex_DRen & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt)
- FSM states: RUN, WAIT_D (fetch done, data pending), WAIT_I (data done, fetch pending), HALT.
- RUN:
  - iREN=1; dREN=exmem_DRen; dWEN=exmem_DWen.
  - adv = ihit & (~mreq | dhit).
  - ihit & mreq & ~dhit -> WAIT_D.
  - ~ihit & mreq & dhit -> WAIT_I.
  - Otherwise stay in RUN.
- WAIT_D:
  - iREN=0 (no refetch); dREN/dWEN as in RUN.
  - adv = dhit; dhit -> RUN.
- WAIT_I:
  - dREN=dWEN=0 (the completed access is never reissued); iREN=1.
  - adv = ihit; ihit -> RUN.
- Advance cycle (adv=1), combinational:
  - All latch enables=1 and pc_en=1, then the overrides below.
  - luh: pc_en=0, ifid_en=0, idex_flush=1 (one bubble). Stall lasts exactly 1 advance cycle.
  - exmem_redirect: ifid_flush=idex_flush=exmem_flush=1, pc_en=1.
  - Redirect has priority over luh: when both are true, pc_en=1 and ifid_en=1.
- Non-advance cycle: pc_en and all latch enables are 0, all flushes are 0, pipeline contents hold.
- HALT:
  - Entered on the clock edge where memwb_halt=1, from any state; exit only by reset.
  - In HALT: halt=1, all enables and flushes 0, iREN=dREN=dWEN=0.
  - In the entry cycle itself, memwb_halt forces memwb_en=0 and pc_en=0.
- stall_cnt:
  - Increments by 1 on each clock edge where state!=HALT, adv=0 and nRST is high.
  - Also counts the luh bubble cycle.
  - Saturates at all-ones; no wrap.
- Reset mid-WAIT: returns to RUN immediately, no outstanding request is remembered, stall_cnt=0.

Test Plan:
- Reset: hold nRST=0 -> all enables 0, stall_cnt=0, halt=0. Release with ihit=1, mreq=0 -> pc_en=1 and all en=1 on the first cycle.
- Load-use: idex_DRen=1, idex_rt=5, ifid_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle, stall_cnt=1. Repeat with idex_rt=0 -> no stall.
- dhit late: exmem_DRen=1, ihit at cycle 0, dhit at cycle 3 -> states WAIT_D for cycles 1-3, iREN=0 in WAIT_D, adv at cycle 3, stall_cnt=3.
- ihit late: exmem_DWen=1, dhit at cycle 0, ihit at cycle 2 -> WAIT_I, dWEN=0 in cycles 1-2 (single write), adv at cycle 2, stall_cnt=2.
- Redirect with luh simultaneously, ihit=1 -> ifid/idex/exmem flush=1, pc_en=1, no luh bubble.
- Halt: memwb_halt=1 -> halt=1 on the next edge and sticky. Clear memwb_halt -> all enables stay 0 until nRST.
- CNT_W=4, hold ihit=0 for 20 cycles -> stall_cnt=15 and it holds there. Assert nRST=0 mid-WAIT_D -> state RUN, stall_cnt=0.
